// File: rtl/cache_pkg.sv
// Shared constants, types and FSM encoding for the cache line memory port.
package cache_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BUS_WIDTH  = 64;
    localparam int ADDR_WIDTH = 64;
    localparam int BEATS      = LINE_BYTES * 8 / BUS_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);

    typedef logic [LINE_BYTES*8-1:0] cache_line_t;
    typedef logic [BUS_WIDTH-1:0]    beat_t;
    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [CNT_W-1:0]        beat_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } mem_port_state_e;

    // rd_wr encoding
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    // Clear the byte-offset bits so the burst starts on a line boundary.
    function automatic addr_t line_align(input addr_t addr);
        return addr & ~addr_t'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/cache_line_mem_port_if.sv
// System memory bus seen by the line port: one request phase, then an
// 8-beat data phase in either direction.
//
// Handshake rules: bus_req/bus_req_addr/bus_req_wr stay stable until the
// cycle bus_req_ack is sampled high; a write beat moves on the rising edge
// where bus_wvalid && bus_wready, with bus_wdata held while bus_wready=0;
// read beats have no backpressure - every cycle with bus_rvalid=1 is a beat.
interface cache_line_mem_port_if;
    import cache_pkg::*;

    logic  bus_req;
    addr_t bus_req_addr;
    logic  bus_req_wr;
    logic  bus_req_ack;
    logic  bus_wvalid;
    beat_t bus_wdata;
    logic  bus_wready;
    logic  bus_rvalid;
    beat_t bus_rdata;

    modport master (
        output bus_req, bus_req_addr, bus_req_wr, bus_wvalid, bus_wdata,
        input  bus_req_ack, bus_wready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_req_addr, bus_req_wr, bus_wvalid, bus_wdata,
        output bus_req_ack, bus_wready, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/line_beat_buffer.sv
// 8 x 64-bit line buffer: whole-line load, single-beat write, beat read mux
// and a flat view of the full line.
module line_beat_buffer
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  cache_line_t load_line,
    input  logic        beat_we,
    input  beat_idx_t   beat_widx,
    input  beat_t       beat_wdata,
    input  beat_idx_t   beat_ridx,
    output beat_t       beat_rdata,
    output cache_line_t line
);

    beat_t mem [BEATS];

    // Parallel load takes priority; otherwise a single beat may be written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= load_line[i*BUS_WIDTH +: BUS_WIDTH];
        end else if (beat_we) begin
            mem[beat_widx] <= beat_wdata;
        end
    end

    assign beat_rdata = mem[beat_ridx];

    // Beat 0 sits in the least significant bits of the line.
    always_comb begin
        line = '0;
        for (int i = 0; i < BEATS; i++) line[i*BUS_WIDTH +: BUS_WIDTH] = mem[i];
    end

endmodule

// File: rtl/cache_line_mem_port.sv
// Memory-side responder for the L1 line fill/flush interface: turns one
// 64-byte line request into an 8-beat bus burst and pulses ready when done.
module cache_line_mem_port
    import cache_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            addr_data_enable,
    input  logic            rd_wr,
    input  addr_t           phy_addr,
    input  cache_line_t     wr_line,
    output logic            addr_data_ready,
    output cache_line_t     rd_line,
    output logic            busy,
    output logic            protocol_err,
    output mem_port_state_e state_dbg,
    cache_line_mem_port_if.master bus
);

    mem_port_state_e state, state_d;
    beat_idx_t       cnt;
    logic            req_wr;
    addr_t           req_addr;
    cache_line_t     rd_line_q;
    cache_line_t     buf_line;
    beat_t           buf_beat;
    logic            accept;
    logic            beat_done;
    logic            fill_done;

    assign accept    = (state == IDLE) && addr_data_enable;
    assign beat_done = ((state == WDATA) && bus.bus_wready) ||
                       ((state == RDATA) && bus.bus_rvalid);
    assign fill_done = (state == DONE) && (req_wr == RD);

    line_beat_buffer u_buf (
        .clk        (clk),
        .reset      (reset),
        .load_en    (accept && (rd_wr == WR)),
        .load_line  (wr_line),
        .beat_we    ((state == RDATA) && bus.bus_rvalid),
        .beat_widx  (cnt),
        .beat_wdata (bus.bus_rdata),
        .beat_ridx  (cnt),
        .beat_rdata (buf_beat),
        .line       (buf_line)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and per-state outputs.
    always_comb begin
        state_d         = state;
        addr_data_ready = 1'b0;
        busy            = 1'b0;
        case (state)
            IDLE: begin
                if (addr_data_enable) state_d = REQ;
            end
            REQ: begin
                busy = 1'b1;
                if (bus.bus_req_ack) state_d = (req_wr == WR) ? WDATA : RDATA;
            end
            WDATA: begin
                busy = 1'b1;
                if (bus.bus_wready && (cnt == LAST_BEAT)) state_d = DONE;
            end
            RDATA: begin
                busy = 1'b1;
                if (bus.bus_rvalid && (cnt == LAST_BEAT)) state_d = DONE;
            end
            DONE: begin
                addr_data_ready = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request; the beat counter wraps 7->0 on the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_wr   <= RD;
            req_addr <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                req_wr   <= rd_wr;
                req_addr <= line_align(phy_addr);
            end
            if (state == IDLE)  cnt <= '0;
            else if (beat_done) cnt <= cnt + 1'b1;
        end
    end

    // Completed fills are latched so rd_line holds until the next fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         rd_line_q <= '0;
        else if (fill_done) rd_line_q <= buf_line;
    end

    // Sticky error: enable while not idle (incl. DONE), or a stray read beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if ((addr_data_enable && (state != IDLE)) ||
                     (bus.bus_rvalid && (state != RDATA))) begin
            protocol_err <= 1'b1;
        end
    end

    assign rd_line          = fill_done ? buf_line : rd_line_q;
    assign state_dbg        = state;
    assign bus.bus_req      = (state == REQ);
    assign bus.bus_req_addr = req_addr;
    assign bus.bus_req_wr   = req_wr;
    assign bus.bus_wvalid   = (state == WDATA);
    assign bus.bus_wdata    = (state == WDATA) ? buf_beat : '0;

endmodule

// File: tb/tb_cache_line_mem_port.sv
// Directed plus randomized bench for cache_line_mem_port; the bench plays
// both the cache and the memory bus and predicts results from line rules.
module tb_cache_line_mem_port;
    import cache_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            addr_data_enable;
    logic            rd_wr;
    addr_t           phy_addr;
    cache_line_t     wr_line;
    logic            addr_data_ready;
    cache_line_t     rd_line;
    logic            busy;
    logic            protocol_err;
    mem_port_state_e state_dbg;

    cache_line_mem_port_if bus_if ();

    cache_line_mem_port dut (
        .clk              (clk),
        .reset            (reset),
        .addr_data_enable (addr_data_enable),
        .rd_wr            (rd_wr),
        .phy_addr         (phy_addr),
        .wr_line          (wr_line),
        .addr_data_ready  (addr_data_ready),
        .rd_line          (rd_line),
        .busy             (busy),
        .protocol_err     (protocol_err),
        .state_dbg        (state_dbg),
        .bus              (bus_if.master)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int          tests_run = 0;
    int          failed    = 0;
    int          cyc       = 0;
    int          inj_cyc   = -1;
    int          ready_cnt = 0;
    int          breq_cnt  = 0;
    logic        breq_prev = 1'b0;
    beat_t       rbeat [BEATS];
    int          stall [BEATS];
    beat_t       exp_q [$];
    cache_line_t last_rd_line;

    // Event counters for ready pulses and new bus requests.
    always @(posedge clk) begin
        #1;
        if (addr_data_ready) ready_cnt++;
        if (bus_if.bus_req && !breq_prev) breq_cnt++;
        breq_prev = bus_if.bus_req;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; drives the enable low unless an injected enable is due.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc == inj_cyc) begin
            addr_data_enable = 1'b1;
            rd_wr            = 1'b1;
            phy_addr         = 64'hDEAD_BEEF_0000_0000;
        end else begin
            addr_data_enable = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, addr_data_ready, 1'b0);
        check({tag, "_rd_line"}, rd_line, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, protocol_err, 1'b0);
        check({tag, "_bus_req"}, bus_if.bus_req, 1'b0);
        check({tag, "_req_addr"}, bus_if.bus_req_addr, '0);
        check({tag, "_req_wr"}, bus_if.bus_req_wr, 1'b0);
        check({tag, "_wvalid"}, bus_if.bus_wvalid, 1'b0);
        check({tag, "_wdata"}, bus_if.bus_wdata, '0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    task automatic clear_stalls();
        foreach (stall[b]) stall[b] = 0;
    endtask

    task automatic random_beats();
        foreach (rbeat[b]) rbeat[b] = {$urandom, $urandom};
    endtask

    // Full transaction: cache enable, bus request/ack, 8 beats, ready pulse.
    task automatic run_txn(input string tag, input logic wr, input addr_t addr,
                           input cache_line_t wline, input int ack_dly);
        int          en_cyc;
        int          lat_exp;
        int          rdy0;
        int          breq0;
        addr_t       exp_addr;
        cache_line_t exp_line;
        exp_addr = {addr[63:6], 6'b0};
        lat_exp  = 11 + ack_dly;
        foreach (stall[b]) lat_exp += stall[b];
        exp_line = '0;
        if (wr) begin
            for (int b = 0; b < BEATS; b++) exp_q.push_back(wline[b*64 +: 64]);
        end else begin
            for (int b = 0; b < BEATS; b++) exp_line[b*64 +: 64] = rbeat[b];
        end
        rdy0  = ready_cnt;
        breq0 = breq_cnt;

        rd_wr            = wr;
        phy_addr         = addr;
        wr_line          = wline;
        addr_data_enable = 1'b1;
        en_cyc           = cyc;
        step();
        check({tag, "_busy_req"}, busy, 1'b1);
        check({tag, "_bus_req"}, bus_if.bus_req, 1'b1);
        check({tag, "_req_addr"}, bus_if.bus_req_addr, exp_addr);
        check({tag, "_req_wr"}, bus_if.bus_req_wr, wr);
        for (int k = 0; k < ack_dly; k++) begin
            step();
            check({tag, "_req_hold"}, bus_if.bus_req, 1'b1);
            check({tag, "_addr_hold"}, bus_if.bus_req_addr, exp_addr);
        end
        bus_if.bus_req_ack = 1'b1;
        step();
        bus_if.bus_req_ack = 1'b0;
        check({tag, "_req_drop"}, bus_if.bus_req, 1'b0);

        for (int b = 0; b < BEATS; b++) begin
            if (wr) begin
                for (int s = 0; s < stall[b]; s++) begin
                    bus_if.bus_wready = 1'b0;
                    check({tag, "_wvalid_stall"}, bus_if.bus_wvalid, 1'b1);
                    check({tag, "_wdata_hold"}, bus_if.bus_wdata, exp_q[0]);
                    step();
                end
                bus_if.bus_wready = 1'b1;
                check({tag, "_wvalid"}, bus_if.bus_wvalid, 1'b1);
                check({tag, "_wdata"}, bus_if.bus_wdata, exp_q.pop_front());
                step();
                bus_if.bus_wready = 1'b0;
            end else begin
                for (int s = 0; s < stall[b]; s++) begin
                    check({tag, "_busy_gap"}, busy, 1'b1);
                    step();
                end
                bus_if.bus_rvalid = 1'b1;
                bus_if.bus_rdata  = rbeat[b];
                step();
                bus_if.bus_rvalid = 1'b0;
                bus_if.bus_rdata  = '0;
            end
        end

        check({tag, "_ready"}, addr_data_ready, 1'b1);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_latency"}, cyc - en_cyc + 1, lat_exp);
        if (wr) begin
            check({tag, "_rd_line_kept"}, rd_line, last_rd_line);
        end else begin
            check({tag, "_rd_line"}, rd_line, exp_line);
            last_rd_line = exp_line;
        end
        step();
        check({tag, "_ready_drop"}, addr_data_ready, 1'b0);
        check({tag, "_state_idle"}, state_dbg, IDLE);
        check({tag, "_rd_line_held"}, rd_line, last_rd_line);
        check({tag, "_ready_pulses"}, ready_cnt - rdy0, 1);
        check({tag, "_bus_reqs"}, breq_cnt - breq0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cache_line_t wl;
        int          r0;
        int          b0;

        reset             = 1'b0;
        addr_data_enable  = 1'b0;
        rd_wr             = 1'b0;
        phy_addr          = '0;
        wr_line           = '0;
        bus_if.bus_req_ack = 1'b0;
        bus_if.bus_wready = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        last_rd_line      = '0;
        clear_stalls();

        // Reset values
        step();
        step();
        check_outputs_zero("reset");
        reset = 1'b1;
        step();

        // Zero-stall read of beats 0..7
        foreach (rbeat[b]) rbeat[b] = beat_t'(b);
        run_txn("rd0", RD, 64'h1000_0040, '0, 0);
        check("rd0_low_beat", rd_line[63:0], 64'h0);
        check("rd0_high_beat", rd_line[511:448], 64'h7);

        // Write with ack delay and wready stalls on beats 2 and 5
        wl = '0;
        for (int b = 0; b < BEATS; b++) wl[b*64 +: 64] = 64'hA0 + 64'(b);
        foreach (stall[b]) stall[b] = (b == 2 || b == 5) ? 2 : 0;
        run_txn("wr0", WR, 64'h2000_007F, wl, 3);

        // Randomized mix: gapped reads and stalled writes
        for (int i = 0; i < 6; i++) begin
            random_beats();
            for (int b = 0; b < BEATS; b++) wl[b*64 +: 64] = {$urandom, $urandom};
            foreach (stall[b]) stall[b] = $urandom_range(0, 4);
            run_txn((i % 2 == 0) ? "rnd_rd" : "rnd_wr", logic'(i % 2), {$urandom, $urandom},
                    wl, $urandom_range(0, 3));
        end
        check("err_clean", protocol_err, 1'b0);

        // Second enable four cycles into a read is dropped
        random_beats();
        clear_stalls();
        inj_cyc = cyc + 4;
        run_txn("ovl", RD, 64'h4000_0080, '0, 0);
        inj_cyc = -1;
        check("ovl_err", protocol_err, 1'b1);
        b0 = breq_cnt;
        repeat (3) step();
        check("ovl_no_req", breq_cnt - b0, 0);

        // Reset after beat 3 of a read
        r0 = ready_cnt;
        rd_wr            = RD;
        phy_addr         = 64'h3000_0000;
        addr_data_enable = 1'b1;
        step();
        bus_if.bus_req_ack = 1'b1;
        step();
        bus_if.bus_req_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata  = {$urandom, $urandom};
            step();
        end
        bus_if.bus_rvalid = 1'b0;
        check("mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        last_rd_line = '0;
        step();
        reset = 1'b1;
        step();
        check("mid_no_ready", ready_cnt - r0, 0);
        random_beats();
        run_txn("post_rst", RD, 64'h3000_0000, '0, 0);

        // Stray bus activity while idle
        r0 = ready_cnt;
        bus_if.bus_req_ack = 1'b1;
        bus_if.bus_wready  = 1'b1;
        step();
        bus_if.bus_req_ack = 1'b0;
        bus_if.bus_wready  = 1'b0;
        check("stray_ack_state", state_dbg, IDLE);
        check("stray_ack_req", bus_if.bus_req, 1'b0);
        check("stray_ack_wvalid", bus_if.bus_wvalid, 1'b0);
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 64'h1234;
        step();
        bus_if.bus_rvalid = 1'b0;
        check("stray_rv_err", protocol_err, 1'b1);
        check("stray_rv_state", state_dbg, IDLE);
        check("stray_rv_busy", busy, 1'b0);
        check("stray_rv_line", rd_line, last_rd_line);
        check("stray_no_ready", ready_cnt - r0, 0);

        // Enable during the ready cycle is dropped
        reset = 1'b0;
        step();
        last_rd_line = '0;
        check("rst2_err", protocol_err, 1'b0);
        reset = 1'b1;
        step();
        random_beats();
        clear_stalls();
        inj_cyc = cyc + 10;
        run_txn("done_en", RD, 64'h5000_00C0, '0, 0);
        inj_cyc = -1;
        b0 = breq_cnt;
        repeat (3) step();
        check("done_en_err", protocol_err, 1'b1);
        check("done_en_no_req", breq_cnt - b0, 0);
        check("done_en_state", state_dbg, IDLE);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
